spi_rx_axis_master: RTL

//   SPI receiver (mode 0, MSB first, ss active-low) that deserialises sclk/mosi/ss into width-bit

---
 rtl/spi_rx_axis_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_rx_axis_master.sv
// SPI mode-0 receiver (MSB first, ss active-low) feeding an AXI4-Stream master through a small FIFO.
// sclk/mosi/ss are asynchronous to M_AXIS_ACLK and are oversampled; each width-bit word becomes a
// single-beat AXIS packet.
module spi_rx_axis_master #(
  parameter int unsigned width                = 8,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH           = 4
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                sclk,
  input  logic                                mosi,
  input  logic                                ss,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                overrun,
  output logic                                frame_err
);

  localparam int unsigned CntW = $clog2(width + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

  // Synchroniser chains; bit 2 of sclk/ss is only used for edge detection
  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [2:0] ss_sync_q;

  // Receiver state
  logic [width-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_q;
  logic [width-1:0] push_data_q;

  // FIFO state
  logic [width-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [OccW-1:0]  occ_q;

  logic             sclk_rise;
  logic             ss_rise;
  logic             ss_active;
  logic             last_bit;
  logic [width:0]   shift_ext;
  logic [width-1:0] shift_next;
  logic             full;
  logic             pop;
  logic             do_push;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_active  = ~ss_sync_q[1];
  assign last_bit   = (cnt_q == CntW'(width - 1));
  // Built one bit wider so width=1 needs no special-case slice
  assign shift_ext  = {shift_q, mosi_sync_q[1]};
  assign shift_next = shift_ext[width-1:0];

  assign full    = (occ_q == OccW'(FIFO_DEPTH));
  assign pop     = M_AXIS_TVALID & M_AXIS_TREADY;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign do_push = push_q & (~full | pop);

  assign M_AXIS_TVALID = (occ_q != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? C_M_AXIS_TDATA_WIDTH'(mem_q[rd_ptr_q]) : '0;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = M_AXIS_TVALID;

  // Two/three-flop synchronisers, reset to the idle bus state
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 3'b111;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      ss_sync_q   <= {ss_sync_q[1:0], ss};
    end
  end

  // Bit sampling, word assembly and partial-frame detection
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err   <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      if (sclk_rise && ss_active) begin
        shift_q <= shift_next;
        if (last_bit) begin
          cnt_q       <= '0;
          push_q      <= 1'b1;
          push_data_q <= shift_next;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (ss_rise) begin
        frame_err <= (cnt_q != '0);
        cnt_q     <= '0;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overrun flag
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      overrun  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (push_q && full && !pop) overrun <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, TDATA is masked while empty
  always_ff @(posedge M_AXIS_ACLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_q;
  end

endmodule
